dbus_ctrl: RTL

Data-bus handshake controller between the MEM stage and the external data memory. It turns the single-cycle access request held in the EX/MEM register into a held bus transaction on DAD/DDT/MREQ/WRITE/SIZE. It waits for ACKD_n and freezes the pipeline through core_stall until the access completes. It then presents captured read data to MEM/WB.

---
 rtl/dbus_ctrl_pkg.sv | 17 +
 rtl/dbus_timeout.sv | 31 +++
 rtl/dbus_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dbus_ctrl_pkg.sv
// Shared constants for the data-bus controller: FSM state encodings, bus SIZE codes
// and the width of the optional timeout counter.
package dbus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dbus_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int CNT_W = 16;

endpackage

// File: rtl/dbus_timeout.sv
// REQ-state watchdog for dbus_ctrl: counts no-ACK cycles and flags expiry on the
// edge where the count would reach TIMEOUT_CYC. Only used when DBUS_TIMEOUT_EN is defined.
module dbus_timeout
    import dbus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic ack_n,
    output logic expire
);

    logic [CNT_W-1:0] count_reg;

    // Expiry is qualified by ack_n so an ACK on the same edge completes normally.
    assign expire = active && ack_n && (count_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (active && ack_n) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus handshake controller: holds a MEM-stage access on DAD/DDT/MREQ/WRITE/SIZE
// until ACKD_n, stalling the core meanwhile. Optional REQ timeout via DBUS_TIMEOUT_EN.
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_mreq,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [1:0]  core_size,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_err,
    input  logic        ACKD_n,
    inout  wire  [31:0] DDT,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE
);

    dbus_state_t state_reg, state_next;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  size_reg;
    logic        write_reg;
    logic        req;
    logic        capture;
    logic        ack;
    logic        expire;

    assign req = core_mreq | core_write;
    assign ack = (state_reg == ST_REQ) && !ACKD_n;

    always_comb begin
        state_next = state_reg;
        core_stall = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                core_stall = req;
                if (req) begin
                    capture    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                core_stall = 1'b1;
                if (ack || expire) begin
                    state_next = ST_DONE;
                end
            end
            // The request still visible here is the one just completed.
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= SIZE_BYTE;
            write_reg <= 1'b0;
        end else if (capture) begin
            addr_reg  <= core_addr;
            wdata_reg <= core_wdata;
            size_reg  <= core_size;
            write_reg <= core_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (ack && !write_reg) begin
            rdata_reg <= DDT;
        end else if (expire) begin
            rdata_reg <= '0;
        end
    end

`ifdef DBUS_TIMEOUT_EN
    logic err_reg;

    dbus_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (capture),
        .active (state_reg == ST_REQ),
        .ack_n  (ACKD_n),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= expire;
        end
    end

    assign core_err = err_reg;
`else
    assign expire = 1'b0;
    // Constant 0 for every legal TIMEOUT_CYC.
    assign core_err = (TIMEOUT_CYC == 0);
`endif

    assign core_rdata = rdata_reg;
    assign MREQ       = (state_reg == ST_REQ);
    assign WRITE      = MREQ && write_reg;
    assign DAD        = addr_reg;
    assign SIZE       = size_reg;
    assign DDT        = WRITE ? wdata_reg : 'z;

endmodule
